// File: rtl/maxpool2d_dsp_pkg.sv
// Shared types and constants for the 2x2 stride-2 max-pool engine.
// Holds the FSM encoding, latched job config and byte-address helper.
package maxpool2d_dsp_pkg;

    localparam int WORD_BYTES = 4;
    localparam int POOL = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [31:0] in_base;
        logic [31:0] out_base;
        logic [15:0] w;
        logic [15:0] c;
        logic [15:0] oh;
        logic [15:0] ow;
    } cfg_t;

    function automatic logic [31:0] word_addr(
        input logic [31:0] base,
        input logic [31:0] idx
    );
        return base + idx * 32'(WORD_BYTES);
    endfunction

endpackage

// File: rtl/maxpool2d_dsp_if.sv
// Single-outstanding memory port used by the max-pool engine.
// The engine is master; mem_ready doubles as accept and read-data-valid.
interface maxpool2d_dsp_if;

    logic [31:0] mem_addr;
    logic [31:0] mem_data_out;
    logic [31:0] mem_data_in;
    logic        mem_we;
    logic        mem_re;
    logic        mem_ready;

    modport master (
        output mem_addr, mem_data_out, mem_we, mem_re,
        input  mem_data_in, mem_ready
    );

    modport slave (
        input  mem_addr, mem_data_out, mem_we, mem_re,
        output mem_data_in, mem_ready
    );

endinterface

// File: rtl/maxpool2d_dsp_addr_gen.sv
// HWC read/write address generation for the current window position.
// All arithmetic wraps modulo 2^32.
module maxpool_addr_gen
    import maxpool2d_dsp_pkg::*;
(
    input  logic [31:0] in_base,
    input  logic [31:0] out_base,
    input  logic [15:0] w,
    input  logic [15:0] c_n,
    input  logic [15:0] ow,
    input  logic [15:0] oy,
    input  logic [15:0] ox,
    input  logic [15:0] c,
    input  logic [1:0]  rd_idx,
    output logic [31:0] rd_addr,
    output logic [31:0] wr_addr
);

    logic [31:0] y;
    logic [31:0] x;
    logic [31:0] rd_elem;
    logic [31:0] wr_elem;

    // rd_idx bit 1 selects the lower row, bit 0 the right column.
    always_comb begin
        y = 32'(oy) * 32'(POOL) + 32'(rd_idx[1]);
        x = 32'(ox) * 32'(POOL) + 32'(rd_idx[0]);
        rd_elem = (y * 32'(w) + x) * 32'(c_n) + 32'(c);
        wr_elem = (32'(oy) * 32'(ow) + 32'(ox)) * 32'(c_n)
                + 32'(c);
        rd_addr = word_addr(in_base, rd_elem);
        wr_addr = word_addr(out_base, wr_elem);
    end

endmodule

// File: rtl/maxpool2d_dsp.sv
// 2x2 stride-2 signed max pooling over an int32 HWC tensor in memory.
// Four reads per window, then one write of the running maximum.
module maxpool2d_dsp
    import maxpool2d_dsp_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] input_addr,
    input  logic [31:0] output_addr,
    input  logic [15:0] input_height,
    input  logic [15:0] input_width,
    input  logic [15:0] channels,
    output logic        done,
    output logic        ready,
    output logic [31:0] result,
    maxpool2d_dsp_if.master mem
);

    state_t      state_q, state_d;
    cfg_t        cfg_q, cfg_d;
    logic [15:0] oy_q, oy_d;
    logic [15:0] ox_q, ox_d;
    logic [15:0] c_q, c_d;
    logic [1:0]  rd_idx_q, rd_idx_d;
    logic [31:0] max_q, max_d;
    logic [31:0] result_q, result_d;
    logic        first_q, first_d;

    logic [31:0] rd_addr;
    logic [31:0] wr_addr;
    logic [15:0] oh_in;
    logic [15:0] ow_in;
    logic        last_c;
    logic        last_ox;
    logic        last_oy;
    logic        re;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;

    maxpool_addr_gen u_addr_gen (
        .in_base  (cfg_q.in_base),
        .out_base (cfg_q.out_base),
        .w        (cfg_q.w),
        .c_n      (cfg_q.c),
        .ow       (cfg_q.ow),
        .oy       (oy_q),
        .ox       (ox_q),
        .c        (c_q),
        .rd_idx   (rd_idx_q),
        .rd_addr  (rd_addr),
        .wr_addr  (wr_addr)
    );

    always_comb begin
        state_d  = state_q;
        cfg_d    = cfg_q;
        oy_d     = oy_q;
        ox_d     = ox_q;
        c_d      = c_q;
        rd_idx_d = rd_idx_q;
        max_d    = max_q;
        result_d = result_q;
        first_d  = first_q;
        done     = 1'b0;
        ready    = 1'b0;
        re       = 1'b0;
        we       = 1'b0;
        addr     = '0;
        wdata    = '0;
        oh_in    = input_height >> 1;
        ow_in    = input_width >> 1;
        last_c   = (c_q == cfg_q.c - 16'd1);
        last_ox  = (ox_q == cfg_q.ow - 16'd1);
        last_oy  = (oy_q == cfg_q.oh - 16'd1);

        unique case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    cfg_d = '{in_base:  input_addr,
                              out_base: output_addr,
                              w:        input_width,
                              c:        channels,
                              oh:       oh_in,
                              ow:       ow_in};
                    oy_d     = '0;
                    ox_d     = '0;
                    c_d      = '0;
                    rd_idx_d = '0;
                    max_d    = '0;
                    first_d  = 1'b1;
                    if (oh_in == '0 || ow_in == '0 ||
                        channels == '0)
                        state_d = DONE;
                    else
                        state_d = READ;
                end
            end
            READ: begin
                re   = 1'b1;
                addr = rd_addr;
                if (mem.mem_ready) begin
                    // Ties keep the held value.
                    if (rd_idx_q == 2'd0 ||
                        $signed(mem.mem_data_in) > $signed(max_q))
                        max_d = mem.mem_data_in;
                    rd_idx_d = rd_idx_q + 2'd1;
                    if (rd_idx_q == 2'd3)
                        state_d = WRITE;
                end
            end
            WRITE: begin
                we    = 1'b1;
                addr  = wr_addr;
                wdata = max_q;
                if (mem.mem_ready) begin
                    if (first_q) begin
                        result_d = max_q;
                        first_d  = 1'b0;
                    end
                    state_d = READ;
                    if (!last_c) begin
                        c_d = c_q + 16'd1;
                    end else begin
                        c_d = '0;
                        if (!last_ox) begin
                            ox_d = ox_q + 16'd1;
                        end else begin
                            ox_d = '0;
                            oy_d = oy_q + 16'd1;
                            if (last_oy)
                                state_d = DONE;
                        end
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                ready   = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    assign mem.mem_re       = re;
    assign mem.mem_we       = we;
    assign mem.mem_addr     = addr;
    assign mem.mem_data_out = wdata;
    assign result           = result_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cfg_q    <= '0;
            oy_q     <= '0;
            ox_q     <= '0;
            c_q      <= '0;
            rd_idx_q <= '0;
            max_q    <= '0;
            result_q <= '0;
            first_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cfg_q    <= cfg_d;
            oy_q     <= oy_d;
            ox_q     <= ox_d;
            c_q      <= c_d;
            rd_idx_q <= rd_idx_d;
            max_q    <= max_d;
            result_q <= result_d;
            first_q  <= first_d;
        end
    end

endmodule

// File: tb/tb_maxpool2d_dsp.sv
// Self-checking bench for maxpool2d_dsp: table of jobs against a
// loop-based pooling model, plus reset and stall corner cases.
module tb_maxpool2d_dsp;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] input_addr;
    logic [31:0] output_addr;
    logic [15:0] input_height;
    logic [15:0] input_width;
    logic [15:0] channels;
    logic        done;
    logic        ready;
    logic [31:0] result;

    maxpool2d_dsp_if bus ();

    maxpool2d_dsp dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .input_addr   (input_addr),
        .output_addr  (output_addr),
        .input_height (input_height),
        .input_width  (input_width),
        .channels     (channels),
        .done         (done),
        .ready        (ready),
        .result       (result),
        .mem          (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h",
                     name, act, exp);
        end
    endtask

    // Memory model and access logs
    logic [31:0] mem [logic [31:0]];
    logic [31:0] rd_log [$];
    logic [31:0] wa_log [$];
    logic [31:0] wd_log [$];
    int          duty = 100;

    logic        pend;
    logic        p_re, p_we;
    logic [31:0] p_addr, p_data;

    initial begin
        bus.mem_ready   = 1'b0;
        bus.mem_data_in = '0;
        pend = 1'b0;
    end

    always @(negedge clk) begin
        logic rdy;
        if (!rst_n) begin
            pend = 1'b0;
            bus.mem_ready = 1'b0;
        end else begin
            if (bus.mem_re && bus.mem_we)
                chk("re_we_exclusive", 32'd1, 32'd0);
            if (pend) begin
                chk("stall_re", 32'(bus.mem_re), 32'(p_re));
                chk("stall_we", 32'(bus.mem_we), 32'(p_we));
                chk("stall_addr", bus.mem_addr, p_addr);
                if (p_we)
                    chk("stall_data", bus.mem_data_out, p_data);
            end
            pend = 1'b0;
            bus.mem_data_in = $urandom;
            if (bus.mem_re || bus.mem_we) begin
                rdy = ($urandom_range(99) < duty);
                bus.mem_ready = rdy;
                if (!rdy) begin
                    pend   = 1'b1;
                    p_re   = bus.mem_re;
                    p_we   = bus.mem_we;
                    p_addr = bus.mem_addr;
                    p_data = bus.mem_data_out;
                end else if (bus.mem_re) begin
                    if (!mem.exists(bus.mem_addr))
                        chk("read_in_tensor", bus.mem_addr, 32'hx);
                    else
                        bus.mem_data_in = mem[bus.mem_addr];
                    rd_log.push_back(bus.mem_addr);
                end else begin
                    wa_log.push_back(bus.mem_addr);
                    wd_log.push_back(bus.mem_data_out);
                end
            end else begin
                bus.mem_ready = $urandom_range(1);
            end
        end
    end

    typedef struct {
        int          h;
        int          w;
        int          c;
        logic [31:0] in_base;
        logic [31:0] out_base;
        int          pat;
        int          dty;
        int          exp_wr;
        int          exp_lat;
    } vec_t;

    logic [31:0] exp_result;

    task automatic run_case(input vec_t v);
        int          n_in, oh, ow, n;
        logic [31:0] vals [$];
        logic [31:0] e_rd [$];
        logic [31:0] e_wa [$];
        logic [31:0] e_wd [$];
        logic [31:0] m, a, idx;
        bit          to;

        n_in = v.h * v.w * v.c;
        for (int i = 0; i < n_in; i++) begin
            if (v.pat == 1) begin
                int fixed [4] = '{5, -3, 9, 2};
                vals.push_back(fixed[i]);
            end else if (v.pat == 2)
                vals.push_back(32'(-100 + i));
            else
                vals.push_back($urandom);
        end
        mem.delete();
        for (int i = 0; i < n_in; i++)
            mem[v.in_base + 32'(i) * 4] = vals[i];

        oh = v.h / 2;
        ow = v.w / 2;
        for (int oy = 0; oy < oh; oy++)
            for (int ox = 0; ox < ow; ox++)
                for (int c = 0; c < v.c; c++) begin
                    for (int k = 0; k < 4; k++) begin
                        idx = 32'(((2 * oy + k / 2) * v.w
                              + 2 * ox + k % 2) * v.c + c);
                        a = v.in_base + idx * 4;
                        e_rd.push_back(a);
                        if (k == 0 ||
                            $signed(vals[idx]) > $signed(m))
                            m = vals[idx];
                    end
                    idx = 32'((oy * ow + ox) * v.c + c);
                    e_wa.push_back(v.out_base + idx * 4);
                    e_wd.push_back(m);
                end
        if (e_wd.size() > 0)
            exp_result = e_wd[0];

        rd_log.delete();
        wa_log.delete();
        wd_log.delete();
        duty = v.dty;

        @(posedge clk); #1;
        input_addr   = v.in_base;
        output_addr  = v.out_base;
        input_height = 16'(v.h);
        input_width  = 16'(v.w);
        channels     = 16'(v.c);
        start        = 1'b1;
        @(posedge clk); #1;
        start        = 1'b0;
        input_addr   = $urandom;
        output_addr  = $urandom;
        input_height = 16'($urandom_range(2, 9));
        input_width  = 16'($urandom_range(2, 9));
        channels     = 16'($urandom_range(1, 4));
        if (v.exp_lat > 0)
            chk("first_re", 32'(bus.mem_re), 32'd1);
        n  = 0;
        to = 1'b0;
        while (done !== 1'b1 && !to) begin
            @(posedge clk); #1;
            n++;
            if (n == 2) start = 1'b1;
            if (n == 3) start = 1'b0;
            if (n > 20000) to = 1'b1;
        end
        if (to)
            chk("done_timeout", 32'(n), 32'd0);
        if (v.exp_lat >= 0)
            chk("done_latency", 32'(n), 32'(v.exp_lat));
        chk("ready_in_done", 32'(ready), 32'd1);
        @(posedge clk); #1;
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("ready_idle", 32'(ready), 32'd1);

        chk("read_count", 32'(rd_log.size()), 32'(e_rd.size()));
        chk("write_count", 32'(wa_log.size()), 32'(v.exp_wr));
        for (int i = 0; i < e_rd.size() && i < rd_log.size(); i++)
            chk("read_addr", rd_log[i], e_rd[i]);
        for (int i = 0; i < e_wa.size() && i < wa_log.size(); i++) begin
            chk("write_addr", wa_log[i], e_wa[i]);
            chk("write_data", wd_log[i], e_wd[i]);
        end
        chk("result", result, exp_result);
    endtask

    vec_t tbl [$];

    initial begin
        vec_t r;
        rst_n        = 1'b0;
        start        = 1'b0;
        input_addr   = '0;
        output_addr  = '0;
        input_height = '0;
        input_width  = '0;
        channels     = '0;
        exp_result   = '0;

        #12;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_re", 32'(bus.mem_re), 32'd0);
        chk("rst_we", 32'(bus.mem_we), 32'd0);
        chk("rst_addr", bus.mem_addr, 32'd0);
        chk("rst_wdata", bus.mem_data_out, 32'd0);
        chk("rst_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        //       h  w  c  in_base        out_base      pat dty wr lat
        tbl.push_back('{2, 2, 1, 32'h1000, 32'h2000, 1, 100, 1, 5});
        tbl.push_back('{4, 4, 2, 32'h3000, 32'h4000, 2, 100, 8, 40});
        tbl.push_back('{3, 5, 1, 32'h5000, 32'h6000, 0, 100, 2, 10});
        tbl.push_back('{4, 4, 0, 32'h1000, 32'h2000, 0, 100, 0, 0});
        tbl.push_back('{1, 4, 2, 32'h1000, 32'h2000, 0, 100, 0, 0});
        tbl.push_back('{4, 6, 3, 32'h7000, 32'h8000, 0, 30, 18, -1});
        tbl.push_back('{5, 4, 2, 32'hFFFF_FFE0, 32'hFFFF_FFF8,
                        0, 30, 8, -1});
        for (int i = 0; i < 3; i++) begin
            r.h = $urandom_range(1, 6);
            r.w = $urandom_range(1, 6);
            r.c = $urandom_range(1, 3);
            r.in_base  = $urandom & 32'hFFFF_FFFC;
            r.out_base = $urandom & 32'hFFFF_FFFC;
            r.pat = 0;
            r.dty = 30;
            r.exp_wr  = (r.h / 2) * (r.w / 2) * r.c;
            r.exp_lat = -1;
            tbl.push_back(r);
        end

        foreach (tbl[i])
            run_case(tbl[i]);

        // Reset during the third read of a window
        begin
            int n;
            duty = 100;
            mem.delete();
            for (int i = 0; i < 8; i++)
                mem[32'h9000 + 32'(i) * 4] = $urandom;
            rd_log.delete();
            wa_log.delete();
            wd_log.delete();
            @(posedge clk); #1;
            input_addr   = 32'h9000;
            output_addr  = 32'hA000;
            input_height = 16'd2;
            input_width  = 16'd2;
            channels     = 16'd2;
            start        = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            n = 0;
            while (rd_log.size() < 2 && n < 50) begin
                @(posedge clk); #1;
                n++;
            end
            chk("third_read_pending", 32'(bus.mem_re), 32'd1);
            #2;
            rst_n = 1'b0;
            #1;
            chk("abort_re", 32'(bus.mem_re), 32'd0);
            chk("abort_we", 32'(bus.mem_we), 32'd0);
            chk("abort_addr", bus.mem_addr, 32'd0);
            chk("abort_result", result, 32'd0);
            exp_result = '0;
            repeat (2) @(posedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            #1;
            chk("abort_no_write", 32'(wa_log.size()), 32'd0);
            chk("abort_ready", 32'(ready), 32'd1);
            run_case('{2, 4, 2, 32'hB000, 32'hC000, 0, 100, 4, 20});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
